// File: rtl/posit_pkg.sv
// Shared posit widths, special-value patterns and the decoded-field record.
// Instances with a non-default BITS/ES derive their own widths through calc_rw().
package posit_pkg;

  function automatic int calc_rw(input int bits);
    return $clog2(bits) + 1;
  endfunction

  localparam int POSIT_BITS = 32;
  localparam int POSIT_ES   = 3;
  localparam int POSIT_RW   = calc_rw(POSIT_BITS);

  localparam logic [POSIT_BITS-1:0] POSIT_ZERO = '0;
  localparam logic [POSIT_BITS-1:0] POSIT_NAR  = {1'b1, {(POSIT_BITS-1){1'b0}}};

  typedef struct packed {
    logic                         sign;
    logic                         zero;
    logic                         nar;
    logic [POSIT_RW-1:0]          regime;
    logic [POSIT_ES-1:0]          exp;
    logic [POSIT_RW+POSIT_ES-1:0] scale;
    logic [POSIT_BITS-1:0]        frac;
  } posit_fields_t;

endpackage

// File: rtl/posit_unpacker_pipe_regime.sv
// Combinational regime/exponent/fraction split of a positive posit magnitude.
// The run length comes from a priority encode of the bits that differ from the regime's first bit.
module posit_regime_decode
  import posit_pkg::*;
#(
  parameter int BITS = 32,
  parameter int ES = 3,
  localparam int RW = calc_rw(BITS)
) (
  input  logic [BITS-2:0] mag,
  output logic [RW-1:0]   k,
  output logic [ES-1:0]   exp_field,
  output logic [BITS-1:0] frac
);

  localparam int RB = BITS - 1;
  localparam int MW = RW;

  logic          r0;
  logic [RB-1:0] diff;
  logic [RB-1:0] rem;
  logic [MW-1:0] m;

  always_comb begin
    r0   = mag[RB-1];
    diff = mag ^ {RB{r0}};
    m    = MW'(RB);
    for (int i = 0; i < RB; i++) begin
      if (diff[i]) m = MW'(RB - 1 - i);
    end
    // Shifting out run + terminator; a run reaching the LSB shifts everything out.
    rem       = mag << (m + MW'(1));
    k         = r0 ? (m - MW'(1)) : (MW'(0) - m);
    exp_field = rem[RB-1 -: ES];
    frac      = {rem[RB-ES-1:0], {(ES+1){1'b0}}};
  end

endmodule

// File: rtl/posit_unpacker_pipe.sv
// Two-stage posit decoder: S1 captures sign/magnitude/specials, S2 holds decoded fields.
// in_ready is combinational from out_ready (no skid buffer).
module posit_unpacker_pipe
  import posit_pkg::*;
#(
  parameter int BITS = 32,
  parameter int ES = 3,
  localparam int RW = calc_rw(BITS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BITS-1:0]    in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign,
  output logic               out_zero,
  output logic               out_nar,
  output logic [RW-1:0]      out_regime,
  output logic [ES-1:0]      out_exp,
  output logic [RW+ES-1:0]   out_scale,
  output logic [BITS-1:0]    out_frac
);

  localparam logic [BITS-2:0] MAG_ONE = {{(BITS-2){1'b0}}, 1'b1};

  logic            s1_valid, s1_sign, s1_zero, s1_nar;
  logic [BITS-2:0] s1_mag;
  logic            s1_adv, s2_adv;
  logic            in_sign, in_zero, in_nar;
  logic [BITS-2:0] in_mag;
  logic [RW-1:0]   dec_k;
  logic [ES-1:0]   dec_exp;
  logic [BITS-1:0] dec_frac;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Low BITS-1 bits of the two's complement; the dropped MSB is 0 for every non-NaR word.
  assign in_sign = in_data[BITS-1];
  assign in_zero = (in_data == '0);
  assign in_nar  = (in_data == {1'b1, {(BITS-1){1'b0}}});
  assign in_mag  = in_sign ? (~in_data[BITS-2:0] + MAG_ONE) : in_data[BITS-2:0];

  posit_regime_decode #(.BITS(BITS), .ES(ES)) u_regime (
    .mag       (s1_mag),
    .k         (dec_k),
    .exp_field (dec_exp),
    .frac      (dec_frac)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_zero    <= 1'b0;
      s1_nar     <= 1'b0;
      s1_mag     <= '0;
      out_valid  <= 1'b0;
      out_sign   <= 1'b0;
      out_zero   <= 1'b0;
      out_nar    <= 1'b0;
      out_regime <= '0;
      out_exp    <= '0;
      out_scale  <= '0;
      out_frac   <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign <= in_sign;
          s1_zero <= in_zero;
          s1_nar  <= in_nar;
          s1_mag  <= in_mag;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_sign <= s1_sign;
          out_zero <= s1_zero;
          out_nar  <= s1_nar;
          if (s1_zero || s1_nar) begin
            out_regime <= '0;
            out_exp    <= '0;
            out_scale  <= '0;
            out_frac   <= '0;
          end else begin
            out_regime <= dec_k;
            out_exp    <= dec_exp;
            out_scale  <= {dec_k, dec_exp};
            out_frac   <= dec_frac;
          end
        end
      end
    end
  end

endmodule
